control_pipe: RTL and testbench

Pipelined main controller for the 5-stage RV32I core. It decodes the instruction in Decode, drives imm_src_d combinationally to the immediate extender, and carries the remaining control bundle through the D/E, E/M and M/W control registers. It handles the E-stage flush, computes pc_src_e for the fetch mux, and flags unsupported opcodes.

---
 rtl/riscv_ctrl_pkg.sv | 81 ++++++++
 rtl/control_pipe_main_decoder.sv | 68 ++++++
 rtl/control_pipe.sv | 74 +++++++
 tb/tb_control_pipe.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings and control-bundle types for the RV32I pipelined controller.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] ALU_OP_ADD  = 2'b00;
  localparam logic [1:0] ALU_OP_SUB  = 2'b01;
  localparam logic [1:0] ALU_OP_FUNC = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic       jump;
    logic       branch;
    logic [2:0] alu_control;
    logic       alu_src;
    logic       illegal;
  } ctrl_t;

  // Later stages only carry the fields they still consume.
  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
  } mem_ctrl_t;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
  } wb_ctrl_t;

  typedef struct packed {
    logic       legal;
    logic [2:0] alu_control;
  } alu_dec_t;

  function automatic alu_dec_t alu_decode(input logic [1:0] alu_op,
                                          input logic [2:0] funct3,
                                          input logic       op_b5,
                                          input logic       funct7_b5);
    alu_dec_t r;
    r.legal       = 1'b1;
    r.alu_control = ALU_ADD;
    case (alu_op)
      ALU_OP_SUB:  r.alu_control = ALU_SUB;
      ALU_OP_FUNC: begin
        case (funct3)
          3'b000:  r.alu_control = (op_b5 & funct7_b5) ? ALU_SUB : ALU_ADD;
          3'b010:  r.alu_control = ALU_SLT;
          3'b110:  r.alu_control = ALU_OR;
          3'b111:  r.alu_control = ALU_AND;
          default: r.legal = 1'b0;
        endcase
      end
      default:     r.alu_control = ALU_ADD;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/control_pipe_main_decoder.sv
// Combinational Decode-stage decoder: instruction -> control bundle and immediate format.
module main_decoder
  import riscv_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] instr,
  output ctrl_t           ctrl,
  output logic [1:0]      imm_src
);

  logic [6:0] opcode;
  logic [1:0] alu_op;
  alu_dec_t   alu;
  logic       unused_instr;

  assign opcode       = instr[6:0];
  assign unused_instr = ^{instr[XLEN-1:31], instr[29:15], instr[11:7]};
  assign alu          = alu_decode(alu_op, instr[14:12], opcode[5], instr[30]);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    ctrl    = '0;
    imm_src = IMM_I;
    alu_op  = ALU_OP_ADD;
    case (opcode)
      OP_LW: begin
        ctrl.reg_write  = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.result_src = RES_MEM;
      end
      OP_SW: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        imm_src        = IMM_S;
      end
      OP_R: begin
        ctrl.reg_write = 1'b1;
        alu_op         = ALU_OP_FUNC;
      end
      OP_BEQ: begin
        ctrl.branch = 1'b1;
        imm_src     = IMM_B;
        alu_op      = ALU_OP_SUB;
      end
      OP_I: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        alu_op         = ALU_OP_FUNC;
      end
      OP_JAL: begin
        ctrl.reg_write  = 1'b1;
        ctrl.jump       = 1'b1;
        ctrl.result_src = RES_PC4;
        imm_src         = IMM_J;
      end
      default: ctrl.illegal = 1'b1;
    endcase

    ctrl.alu_control = alu.alu_control;
    // An unsupported funct3 must not leave any side effect in flight.
    if (!alu.legal) begin
      ctrl         = '0;
      ctrl.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/control_pipe.sv
// Pipelined main controller: decodes in D and carries control through the E, M and W registers.
module control_pipe
  import riscv_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] instr_d,
  input  logic            flush_e,
  input  logic            zero_e,
  output logic [1:0]      imm_src_d,
  output logic            illegal_d,
  output logic            alu_src_e,
  output logic [2:0]      alu_control_e,
  output logic            branch_e,
  output logic            jump_e,
  output logic            pc_src_e,
  output logic            illegal_e,
  output logic            mem_write_m,
  output logic            reg_write_m,
  output logic [1:0]      result_src_m,
  output logic            reg_write_w,
  output logic [1:0]      result_src_w
);

  ctrl_t     ctrl_dec;
  ctrl_t     ctrl_e_d, ctrl_e_q;
  mem_ctrl_t ctrl_m_d, ctrl_m_q;
  wb_ctrl_t  ctrl_w_d, ctrl_w_q;

  main_decoder #(.XLEN(XLEN)) u_main_decoder (
    .instr   (instr_d),
    .ctrl    (ctrl_dec),
    .imm_src (imm_src_d)
  );

  always_comb begin
    ctrl_e_d            = flush_e ? ctrl_t'('0) : ctrl_dec;
    ctrl_m_d.reg_write  = ctrl_e_q.reg_write;
    ctrl_m_d.result_src = ctrl_e_q.result_src;
    ctrl_m_d.mem_write  = ctrl_e_q.mem_write;
    ctrl_w_d.reg_write  = ctrl_m_q.reg_write;
    ctrl_w_d.result_src = ctrl_m_q.result_src;
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every stage samples the pre-edge values.
    if (reset) begin
      ctrl_e_q <= '0;
      ctrl_m_q <= '0;
      ctrl_w_q <= '0;
    end else begin
      ctrl_e_q <= ctrl_e_d;
      ctrl_m_q <= ctrl_m_d;
      ctrl_w_q <= ctrl_w_d;
    end
  end

  assign illegal_d     = ctrl_dec.illegal;
  assign alu_src_e     = ctrl_e_q.alu_src;
  assign alu_control_e = ctrl_e_q.alu_control;
  assign branch_e      = ctrl_e_q.branch;
  assign jump_e        = ctrl_e_q.jump;
  assign illegal_e     = ctrl_e_q.illegal;
  // Uses the E contents of this cycle, so a concurrent flush cannot cancel it.
  assign pc_src_e      = (ctrl_e_q.branch & zero_e) | ctrl_e_q.jump;
  assign mem_write_m   = ctrl_m_q.mem_write;
  assign reg_write_m   = ctrl_m_q.reg_write;
  assign result_src_m  = ctrl_m_q.result_src;
  assign reg_write_w   = ctrl_w_q.reg_write;
  assign result_src_w  = ctrl_w_q.result_src;

endmodule

// File: tb/tb_control_pipe.sv
// Self-checking bench for control_pipe: directed cases then random traffic against a history model.
module tb_control_pipe;

  typedef struct packed {
    logic       rw;
    logic [1:0] rs;
    logic       mw;
    logic       jmp;
    logic       br;
    logic [2:0] alu;
    logic       asrc;
    logic       ill;
    logic [1:0] imm;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr_d;
  logic        flush_e, zero_e;
  logic [1:0]  imm_src_d;
  logic        illegal_d, alu_src_e, branch_e, jump_e, pc_src_e, illegal_e;
  logic [2:0]  alu_control_e;
  logic        mem_write_m, reg_write_m, reg_write_w;
  logic [1:0]  result_src_m, result_src_w;

  int total = 0;
  int bad   = 0;

  // hist[0] = instruction now in E, hist[1] in M, hist[2] in W.
  exp_t hist [3];

  localparam logic [31:0] I_LW   = 32'hFFC4A303;
  localparam logic [31:0] I_SW   = 32'h0064A423;
  localparam logic [31:0] I_SUB  = 32'h40628233;
  localparam logic [31:0] I_ADD  = 32'h00628233;
  localparam logic [31:0] I_BEQ  = 32'h00420463;
  localparam logic [31:0] I_JAL  = 32'h008000EF;
  localparam logic [31:0] I_ADDI = 32'h00000013;
  localparam logic [31:0] I_SLL  = 32'h00629233;

  control_pipe dut (
    .clk           (clk),
    .reset         (reset),
    .instr_d       (instr_d),
    .flush_e       (flush_e),
    .zero_e        (zero_e),
    .imm_src_d     (imm_src_d),
    .illegal_d     (illegal_d),
    .alu_src_e     (alu_src_e),
    .alu_control_e (alu_control_e),
    .branch_e      (branch_e),
    .jump_e        (jump_e),
    .pc_src_e      (pc_src_e),
    .illegal_e     (illegal_e),
    .mem_write_m   (mem_write_m),
    .reg_write_m   (reg_write_m),
    .result_src_m  (result_src_m),
    .reg_write_w   (reg_write_w),
    .result_src_w  (result_src_w)
  );

  always #5 clk = ~clk;

  // Straight from the opcode/funct3 table of the RV32I subset.
  function automatic exp_t model(input logic [31:0] ins);
    exp_t       r;
    logic [6:0] op;
    logic [2:0] f3;
    r  = '0;
    op = ins[6:0];
    f3 = ins[14:12];
    if (op == 7'h03) begin
      r.rw = 1; r.rs = 2'd1; r.asrc = 1;
    end else if (op == 7'h23) begin
      r.mw = 1; r.imm = 2'd1; r.asrc = 1;
    end else if (op == 7'h33 || op == 7'h13) begin
      r.rw   = 1;
      r.asrc = (op == 7'h13);
      if (f3 == 3'd0)      r.alu = (op == 7'h33 && ins[30]) ? 3'd1 : 3'd0;
      else if (f3 == 3'd2) r.alu = 3'd5;
      else if (f3 == 3'd6) r.alu = 3'd3;
      else if (f3 == 3'd7) r.alu = 3'd2;
      else begin
        r = '0; r.ill = 1;
      end
    end else if (op == 7'h63) begin
      r.br = 1; r.imm = 2'd2; r.alu = 3'd1;
    end else if (op == 7'h6F) begin
      r.rw = 1; r.imm = 2'd3; r.jmp = 1; r.rs = 2'd2;
    end else begin
      r.ill = 1;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // For illegal instructions only the side-effect fields are defined.
  task automatic check_all();
    exp_t d, e, m, w;
    d = model(instr_d);
    e = hist[0];
    m = hist[1];
    w = hist[2];
    chk("imm_src_d", 32'(imm_src_d), 32'(d.imm));
    chk("illegal_d", 32'(illegal_d), 32'(d.ill));
    chk("branch_e", 32'(branch_e), 32'(e.br));
    chk("jump_e", 32'(jump_e), 32'(e.jmp));
    chk("illegal_e", 32'(illegal_e), 32'(e.ill));
    chk("pc_src_e", 32'(pc_src_e), 32'((e.br & zero_e) | e.jmp));
    if (!e.ill) begin
      chk("alu_src_e", 32'(alu_src_e), 32'(e.asrc));
      chk("alu_control_e", 32'(alu_control_e), 32'(e.alu));
    end
    chk("mem_write_m", 32'(mem_write_m), 32'(m.mw));
    chk("reg_write_m", 32'(reg_write_m), 32'(m.rw));
    if (!m.ill) chk("result_src_m", 32'(result_src_m), 32'(m.rs));
    chk("reg_write_w", 32'(reg_write_w), 32'(w.rw));
    if (!w.ill) chk("result_src_w", 32'(result_src_w), 32'(w.rs));
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) begin
      hist[0] = '0; hist[1] = '0; hist[2] = '0;
    end else begin
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = flush_e ? exp_t'('0) : model(instr_d);
    end
    #1;
    check_all();
  endtask

  task automatic settle();
    #1;
    check_all();
  endtask

  logic [6:0] ops [6];

  initial begin
    ops[0] = 7'h03; ops[1] = 7'h23; ops[2] = 7'h33;
    ops[3] = 7'h63; ops[4] = 7'h13; ops[5] = 7'h6F;
    hist[0] = '0; hist[1] = '0; hist[2] = '0;
    reset = 1; instr_d = I_ADDI; flush_e = 0; zero_e = 0;
    @(posedge clk); #1;
    tick();
    chk("rst_reg_write_w", 32'(reg_write_w), 32'd0);
    chk("rst_pc_src_e", 32'(pc_src_e), 32'd0);
    reset = 0;

    // lw
    instr_d = I_LW; settle();
    chk("lw_imm_src_d", 32'(imm_src_d), 32'd0);
    tick();
    chk("lw_alu_src_e", 32'(alu_src_e), 32'd1);
    chk("lw_alu_control_e", 32'(alu_control_e), 32'd0);
    instr_d = I_ADDI;
    tick(); tick();
    chk("lw_reg_write_w", 32'(reg_write_w), 32'd1);
    chk("lw_result_src_w", 32'(result_src_w), 32'd1);

    // sw
    instr_d = I_SW; settle();
    chk("sw_imm_src_d", 32'(imm_src_d), 32'd1);
    tick();
    instr_d = I_SW;
    tick();
    chk("sw_mem_write_m", 32'(mem_write_m), 32'd1);
    chk("sw_reg_write_m", 32'(reg_write_m), 32'd0);
    tick();
    chk("sw_reg_write_w", 32'(reg_write_w), 32'd0);

    // sub / add
    instr_d = I_SUB; tick();
    chk("sub_alu_control_e", 32'(alu_control_e), 32'd1);
    chk("sub_alu_src_e", 32'(alu_src_e), 32'd0);
    instr_d = I_ADD; tick();
    chk("add_alu_control_e", 32'(alu_control_e), 32'd0);

    // beq
    instr_d = I_BEQ; settle();
    chk("beq_imm_src_d", 32'(imm_src_d), 32'd2);
    tick();
    instr_d = I_ADDI;
    zero_e = 1; settle();
    chk("beq_taken", 32'(pc_src_e), 32'd1);
    zero_e = 0; settle();
    chk("beq_not_taken", 32'(pc_src_e), 32'd0);

    // jal
    instr_d = I_JAL; settle();
    chk("jal_imm_src_d", 32'(imm_src_d), 32'd3);
    tick();
    instr_d = I_ADDI;
    settle();
    chk("jal_pc_src_z0", 32'(pc_src_e), 32'd1);
    zero_e = 1; settle();
    chk("jal_pc_src_z1", 32'(pc_src_e), 32'd1);
    tick(); tick();
    chk("jal_result_src_w", 32'(result_src_w), 32'd2);
    chk("jal_reg_write_w", 32'(reg_write_w), 32'd1);
    zero_e = 0;

    // lw flushed on its way into E
    instr_d = I_LW; flush_e = 1; tick();
    chk("flush_alu_src_e", 32'(alu_src_e), 32'd0);
    flush_e = 0; instr_d = I_SW; tick();
    chk("flush_reg_write_m", 32'(reg_write_m), 32'd0);
    tick();
    chk("flush_reg_write_w", 32'(reg_write_w), 32'd0);

    // flush while a jump sits in E
    instr_d = I_JAL; tick();
    flush_e = 1; instr_d = I_ADDI; settle();
    chk("flush_jal_pc_src", 32'(pc_src_e), 32'd1);
    tick();
    chk("flush_jal_next_e", 32'(jump_e), 32'd0);
    flush_e = 0;

    // illegal encodings
    instr_d = 32'h0; settle();
    chk("zero_illegal_d", 32'(illegal_d), 32'd1);
    tick();
    chk("zero_illegal_e", 32'(illegal_e), 32'd1);
    instr_d = I_SLL; settle();
    chk("sll_illegal_d", 32'(illegal_d), 32'd1);
    tick();
    chk("zero_reg_write_m", 32'(reg_write_m), 32'd0);
    instr_d = I_ADDI; tick();
    chk("sll_reg_write_m", 32'(reg_write_m), 32'd0);

    // reset mid-flight
    instr_d = I_LW; tick();
    instr_d = I_JAL; tick();
    reset = 1; tick();
    chk("midrst_jump_e", 32'(jump_e), 32'd0);
    chk("midrst_reg_write_m", 32'(reg_write_m), 32'd0);
    chk("midrst_pc_src_e", 32'(pc_src_e), 32'd0);
    reset = 0;

    // random traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] r;
      int k;
      r = $urandom;
      k = $urandom_range(0, 7);
      instr_d = (k < 6) ? {r[31:7], ops[k]} : r;
      flush_e = ($urandom_range(0, 5) == 0);
      zero_e  = r[0];
      reset   = ($urandom_range(0, 40) == 0);
      settle();
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
